// File: rtl/elevator_pkg.sv
// Shared types and helpers for the elevator call queue.
//   call_kind_e : request kinds carried on req_kind
//   dir_e       : SCAN direction state published on dir
//   floor_width : width of a floor-number field for a given floor count
package elevator_pkg;

  typedef enum logic [1:0] {
    CAR     = 2'd0,
    HALL_UP = 2'd1,
    HALL_DN = 2'd2
  } call_kind_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } dir_e;

  // Ceiling log2 of the floor count; a floor count of 2 still needs one bit.
  function automatic int floor_width(input int count);
    int w;
    w = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << w) < 64'(count)) begin
        w = w + 1;
      end else begin
        w = w;
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/elevator_floor_scan.sv
// Combinational scan of the merged call bitmap around the car position.
//   calls         : OR of car, hall-up and hall-down bitmaps
//   current_floor : car position
//   any_above     : some call strictly above current_floor
//   any_below     : some call strictly below current_floor
//   nearest_above : lowest called floor above current_floor (0 if none)
//   nearest_below : highest called floor below current_floor (0 if none)
module elevator_floor_scan
  import elevator_pkg::*;
#(
  parameter  int FLOOR_COUNT = 7,
  localparam int FLOOR_W     = floor_width(FLOOR_COUNT)
) (
  input  logic [FLOOR_COUNT-1:0] calls,
  input  logic [FLOOR_W-1:0]     current_floor,
  output logic                   any_above,
  output logic                   any_below,
  output logic [FLOOR_W-1:0]     nearest_above,
  output logic [FLOOR_W-1:0]     nearest_below
);

  // Walk downward for the above-search and upward for the below-search so
  // the last hit written is the one closest to the car.
  always_comb begin
    any_above     = 1'b0;
    any_below     = 1'b0;
    nearest_above = {FLOOR_W{1'b0}};
    nearest_below = {FLOOR_W{1'b0}};
    for (int f = FLOOR_COUNT - 1; f >= 0; f--) begin
      nearest_above = (calls[f] && (FLOOR_W'(f) > current_floor)) ? FLOOR_W'(f) : nearest_above;
      any_above     = any_above | (calls[f] && (FLOOR_W'(f) > current_floor));
    end
    for (int f = 0; f < FLOOR_COUNT; f++) begin
      nearest_below = (calls[f] && (FLOOR_W'(f) < current_floor)) ? FLOOR_W'(f) : nearest_below;
      any_below     = any_below | (calls[f] && (FLOOR_W'(f) < current_floor));
    end
  end

endmodule

// File: rtl/elevator_call_queue.sv
// Elevator call queue: car / hall-up / hall-down bitmaps, arrival clearing
// and a SCAN direction FSM that publishes the next target floor.
//   clk, reset        : clock, synchronous active-high reset
//   req_valid/kind/floor : call request (kind 3 and impossible calls rejected)
//   arrive_valid/floor   : car stopped at a floor; clears the served calls
//   current_floor     : car position from the motion controller
//   car_calls, hall_up, hall_dn : registered call bitmaps
//   dir               : registered direction (IDLE/UP/DOWN)
//   target_valid/floor: registered next stop
//   req_error         : one-cycle pulse after a rejected request
module elevator_call_queue
  import elevator_pkg::*;
#(
  parameter  int FLOOR_COUNT = 7,
  localparam int FLOOR_W     = floor_width(FLOOR_COUNT)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  input  logic [1:0]             req_kind,
  input  logic [FLOOR_W-1:0]     req_floor,
  input  logic                   arrive_valid,
  input  logic [FLOOR_W-1:0]     arrive_floor,
  input  logic [FLOOR_W-1:0]     current_floor,
  output logic [FLOOR_COUNT-1:0] car_calls,
  output logic [FLOOR_COUNT-1:0] hall_up,
  output logic [FLOOR_COUNT-1:0] hall_dn,
  output logic [1:0]             dir,
  output logic                   target_valid,
  output logic [FLOOR_W-1:0]     target_floor,
  output logic                   req_error
);

  localparam logic [FLOOR_W:0]       FLOOR_LIMIT = (FLOOR_W + 1)'(FLOOR_COUNT);
  localparam logic [FLOOR_W-1:0]     TOP_FLOOR   = FLOOR_W'(FLOOR_COUNT - 1);
  localparam logic [FLOOR_COUNT-1:0] BIT0        = {{(FLOOR_COUNT - 1){1'b0}}, 1'b1};

  logic [FLOOR_COUNT-1:0] car_q, car_d, up_q, up_d, dn_q, dn_d;
  logic                   err_q, err_d;
  dir_e                   dir_q, dir_d;
  logic                   tv_q, tv_d;
  logic [FLOOR_W-1:0]     tf_q, tf_d;

  logic [FLOOR_COUNT-1:0] req_mask_s, arr_mask_s;
  logic                   req_in_range_s, arr_in_range_s;
  logic                   any_above_s, any_below_s;
  logic [FLOOR_W-1:0]     nearest_above_s, nearest_below_s;

  assign req_mask_s     = BIT0 << req_floor;
  assign arr_mask_s     = BIT0 << arrive_floor;
  assign req_in_range_s = ({1'b0, req_floor} < FLOOR_LIMIT);
  assign arr_in_range_s = ({1'b0, arrive_floor} < FLOOR_LIMIT);

  // The FSM looks at the registered bitmaps, so a new call steers it one edge later.
  elevator_floor_scan #(.FLOOR_COUNT(FLOOR_COUNT)) u_scan (
    .calls         (car_q | up_q | dn_q),
    .current_floor (current_floor),
    .any_above     (any_above_s),
    .any_below     (any_below_s),
    .nearest_above (nearest_above_s),
    .nearest_below (nearest_below_s)
  );

  // Bitmap next state: apply the request first, then the arrival clear so a
  // same-cycle collision on one bit resolves to cleared.
  always_comb begin
    car_d = car_q;
    up_d  = up_q;
    dn_d  = dn_q;
    err_d = 1'b0;
    if (req_valid) begin
      case (req_kind)
        CAR:     if (req_in_range_s) car_d = car_d | req_mask_s;
                 else err_d = 1'b1;
        HALL_UP: if (req_in_range_s && (req_floor != TOP_FLOOR)) up_d = up_d | req_mask_s;
                 else err_d = 1'b1;
        HALL_DN: if (req_in_range_s && (req_floor != {FLOOR_W{1'b0}})) dn_d = dn_d | req_mask_s;
                 else err_d = 1'b1;
        default: err_d = 1'b1;
      endcase
    end else begin
      err_d = 1'b0;
    end
    if (arrive_valid && arr_in_range_s) begin
      car_d = car_d & ~arr_mask_s;
      case (dir_q)
        UP:      up_d = up_d & ~arr_mask_s;
        DOWN:    dn_d = dn_d & ~arr_mask_s;
        default: begin
          up_d = up_d & ~arr_mask_s;
          dn_d = dn_d & ~arr_mask_s;
        end
      endcase
    end else begin
      car_d = car_d;
    end
  end

  // SCAN direction and target; IDLE prefers UP when calls lie on both sides.
  always_comb begin
    dir_d = IDLE;
    tv_d  = 1'b0;
    tf_d  = {FLOOR_W{1'b0}};
    case (dir_q)
      DOWN: begin
        if (any_below_s)      dir_d = DOWN;
        else if (any_above_s) dir_d = UP;
        else                  dir_d = IDLE;
      end
      default: begin
        if (any_above_s)      dir_d = UP;
        else if (any_below_s) dir_d = DOWN;
        else                  dir_d = IDLE;
      end
    endcase
    case (dir_d)
      UP: begin
        tv_d = 1'b1;
        tf_d = nearest_above_s;
      end
      DOWN: begin
        tv_d = 1'b1;
        tf_d = nearest_below_s;
      end
      default: begin
        tv_d = 1'b0;
        tf_d = {FLOOR_W{1'b0}};
      end
    endcase
  end

  // State registers with synchronous reset that discards every pending call.
  always_ff @(posedge clk) begin
    if (reset) begin
      car_q <= {FLOOR_COUNT{1'b0}};
      up_q  <= {FLOOR_COUNT{1'b0}};
      dn_q  <= {FLOOR_COUNT{1'b0}};
      err_q <= 1'b0;
      dir_q <= IDLE;
      tv_q  <= 1'b0;
      tf_q  <= {FLOOR_W{1'b0}};
    end else begin
      car_q <= car_d;
      up_q  <= up_d;
      dn_q  <= dn_d;
      err_q <= err_d;
      dir_q <= dir_d;
      tv_q  <= tv_d;
      tf_q  <= tf_d;
    end
  end

  assign car_calls    = car_q;
  assign hall_up      = up_q;
  assign hall_dn      = dn_q;
  assign dir          = dir_q;
  assign target_valid = tv_q;
  assign target_floor = tf_q;
  assign req_error    = err_q;

endmodule

// File: tb/tb_elevator_call_queue.sv
// Directed self-checking bench for elevator_call_queue with 7 floors.
module tb_elevator_call_queue;

  localparam int FC = 7;
  localparam int FW = 3;

  logic          clk;
  logic          reset;
  logic          req_valid;
  logic [1:0]    req_kind;
  logic [FW-1:0] req_floor;
  logic          arrive_valid;
  logic [FW-1:0] arrive_floor;
  logic [FW-1:0] current_floor;
  logic [FC-1:0] car_calls, hall_up, hall_dn;
  logic [1:0]    dir;
  logic          target_valid;
  logic [FW-1:0] target_floor;
  logic          req_error;

  int checks_cnt;
  int errors_cnt;

  elevator_call_queue #(.FLOOR_COUNT(FC)) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_kind      (req_kind),
    .req_floor     (req_floor),
    .arrive_valid  (arrive_valid),
    .arrive_floor  (arrive_floor),
    .current_floor (current_floor),
    .car_calls     (car_calls),
    .hall_up       (hall_up),
    .hall_dn       (hall_dn),
    .dir           (dir),
    .target_valid  (target_valid),
    .target_floor  (target_floor),
    .req_error     (req_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks_cnt++;
    if (observed !== expected) begin
      errors_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // One rising edge, then settle so outputs are sampled away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic v, input logic [1:0] k, input logic [FW-1:0] f);
    req_valid = v;
    req_kind  = k;
    req_floor = f;
  endtask

  task automatic arrive(input logic v, input logic [FW-1:0] f);
    arrive_valid = v;
    arrive_floor = f;
  endtask

  initial begin
    checks_cnt = 0;
    errors_cnt = 0;
    reset = 1'b1;
    current_floor = 3'd0;
    req(1'b1, 2'd0, 3'd4);
    arrive(1'b0, 3'd0);

    // Reset held 3 edges while a request is presented
    repeat (3) step();
    check_eq("rst_car", car_calls, 7'b0000000);
    check_eq("rst_up", hall_up, 7'b0000000);
    check_eq("rst_dn", hall_dn, 7'b0000000);
    check_eq("rst_dir", dir, 2'd0);
    check_eq("rst_tv", target_valid, 1'b0);
    check_eq("rst_tf", target_floor, 3'd0);
    check_eq("rst_err", req_error, 1'b0);
    reset = 1'b0;
    req(1'b0, 2'd0, 3'd0);
    step();
    check_eq("post_rst_car", car_calls, 7'b0000000);
    check_eq("post_rst_dir", dir, 2'd0);

    // Upward request from floor 0
    req(1'b1, 2'd0, 3'd2);
    step();
    check_eq("up_car", car_calls, 7'b0000100);
    check_eq("up_dir_lat", dir, 2'd0);
    check_eq("up_err", req_error, 1'b0);
    req(1'b0, 2'd0, 3'd0);
    step();
    check_eq("up_dir", dir, 2'd1);
    check_eq("up_tv", target_valid, 1'b1);
    check_eq("up_tf", target_floor, 3'd2);

    // Rejections back to back
    req(1'b1, 2'd1, 3'd6);
    step();
    check_eq("rej_hu_top", req_error, 1'b1);
    req(1'b1, 2'd2, 3'd0);
    step();
    check_eq("rej_hd_bot", req_error, 1'b1);
    req(1'b1, 2'd0, 3'd7);
    step();
    check_eq("rej_range", req_error, 1'b1);
    req(1'b1, 2'd3, 3'd3);
    step();
    check_eq("rej_kind", req_error, 1'b1);
    req(1'b0, 2'd0, 3'd0);
    step();
    check_eq("rej_end", req_error, 1'b0);
    check_eq("rej_car", car_calls, 7'b0000100);
    check_eq("rej_up", hall_up, 7'b0000000);
    check_eq("rej_dn", hall_dn, 7'b0000000);
    check_eq("rej_dir", dir, 2'd1);

    // Arrival clear at floor 3 while moving up
    req(1'b1, 2'd0, 3'd3); step();
    req(1'b1, 2'd1, 3'd3); step();
    req(1'b1, 2'd2, 3'd3); step();
    req(1'b0, 2'd0, 3'd0);
    check_eq("ac_pre_car", car_calls, 7'b0001100);
    check_eq("ac_pre_up", hall_up, 7'b0001000);
    check_eq("ac_pre_dn", hall_dn, 7'b0001000);
    check_eq("ac_pre_tf", target_floor, 3'd2);
    current_floor = 3'd3;
    arrive(1'b1, 3'd3);
    step();
    check_eq("ac_car", car_calls, 7'b0000100);
    check_eq("ac_up", hall_up, 7'b0000000);
    check_eq("ac_dn", hall_dn, 7'b0001000);
    check_eq("ac_dir", dir, 2'd2);
    check_eq("ac_tf", target_floor, 3'd2);
    arrive(1'b0, 3'd0);
    step();
    check_eq("ac_dir2", dir, 2'd2);
    current_floor = 3'd2;
    arrive(1'b1, 3'd2);
    step();
    check_eq("ac2_car", car_calls, 7'b0000000);
    check_eq("ac2_dir", dir, 2'd1);
    check_eq("ac2_tf", target_floor, 3'd3);
    current_floor = 3'd3;
    arrive(1'b1, 3'd3);
    step();
    check_eq("ac3_dn_kept", hall_dn, 7'b0001000);
    check_eq("ac3_dir", dir, 2'd0);
    check_eq("ac3_tv", target_valid, 1'b0);
    check_eq("ac3_tf", target_floor, 3'd0);
    step();
    check_eq("idle_clear_dn", hall_dn, 7'b0000000);
    arrive(1'b0, 3'd0);

    // Reversal from UP at floor 4 to a hall-down call at floor 1
    current_floor = 3'd4;
    req(1'b1, 2'd0, 3'd6); step();
    req(1'b0, 2'd0, 3'd0); step();
    check_eq("rv_dir_up", dir, 2'd1);
    check_eq("rv_tf6", target_floor, 3'd6);
    req(1'b1, 2'd2, 3'd1); step();
    req(1'b0, 2'd0, 3'd0);
    check_eq("rv_dn", hall_dn, 7'b0000010);
    arrive(1'b1, 3'd6);
    step();
    check_eq("rv_car", car_calls, 7'b0000000);
    check_eq("rv_dir_stale", dir, 2'd1);
    arrive(1'b0, 3'd0);
    step();
    check_eq("rv_dir_dn", dir, 2'd2);
    check_eq("rv_tf1", target_floor, 3'd1);
    current_floor = 3'd1;
    arrive(1'b1, 3'd1);
    step();
    check_eq("rv_dn_clr", hall_dn, 7'b0000000);
    arrive(1'b0, 3'd0);
    step();
    check_eq("rv_idle", dir, 2'd0);
    check_eq("rv_tv", target_valid, 1'b0);

    // Collision: clear wins over a same-cycle request
    req(1'b1, 2'd0, 3'd5);
    arrive(1'b1, 3'd5);
    step();
    check_eq("col_car", car_calls, 7'b0000000);
    arrive(1'b0, 3'd0);

    // Tie from IDLE: calls at 1 and 5 with car at 3 -> UP to 5
    req(1'b1, 2'd0, 3'd1); step();
    req(1'b1, 2'd0, 3'd5); step();
    req(1'b0, 2'd0, 3'd0);
    check_eq("tie_car", car_calls, 7'b0100010);
    check_eq("tie_pre_dir", dir, 2'd0);
    current_floor = 3'd3;
    step();
    check_eq("tie_dir", dir, 2'd1);
    check_eq("tie_tv", target_valid, 1'b1);
    check_eq("tie_tf", target_floor, 3'd5);

    // Reset mid-operation drops everything
    reset = 1'b1;
    step();
    check_eq("mrst_car", car_calls, 7'b0000000);
    check_eq("mrst_dir", dir, 2'd0);
    check_eq("mrst_tv", target_valid, 1'b0);
    reset = 1'b0;
    step();
    check_eq("mrst_post_car", car_calls, 7'b0000000);
    check_eq("mrst_post_dir", dir, 2'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
